// File: rtl/write_data.sv
// write_data: frame sink that writes even/odd RGB pixel pairs as 48-bit BMP-ordered words,
// tracking row/pair-column position, frame completion and protocol errors.
module write_data #(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int ADDR_WIDTH   = 18,
  parameter int BOTTOM_UP    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vertical_Pulse,
  input  logic                  horizontal_Pulse,
  input  logic [7:0]            data_R_Even,
  input  logic [7:0]            data_G_Even,
  input  logic [7:0]            data_B_Even,
  input  logic [7:0]            data_R_Odd,
  input  logic [7:0]            data_G_Odd,
  input  logic [7:0]            data_B_Odd,
  output logic                  mem_Write_Enable,
  output logic [ADDR_WIDTH-1:0] mem_Address,
  output logic [47:0]           mem_Write_Data,
  output logic                  done_Flag,
  output logic                  frame_Error,
  output logic [7:0]            frame_Count
);
  localparam int PAIRS = IMAGE_WIDTH / 2;
  localparam int CW = PAIRS > 1 ? $clog2(PAIRS) : 1;
  localparam int RW = IMAGE_HEIGHT > 1 ? $clog2(IMAGE_HEIGHT) : 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t                 state_q, state_d;
  logic                   vsync_q;
  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic                   we_q;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [47:0]            data_q, data_d;
  logic                   done_q, err_q, err_d;
  logic [7:0]             cnt_q;
  logic                   vs_rise, accept, col_end, last;
  logic [31:0]            row_eff;
  always_comb begin
    vs_rise = vertical_Pulse & ~vsync_q;
    accept  = state_q == ACTIVE && horizontal_Pulse && !vs_rise;
    col_end = 32'(col_q) == 32'(PAIRS - 1);
    last    = accept && col_end && 32'(row_q) == 32'(IMAGE_HEIGHT - 1);
    state_d = vs_rise ? ACTIVE : last ? DONE : state_q;
    col_d   = vs_rise || (accept && col_end) ? '0 : accept ? col_q + CW'(1) : col_q;
    row_d   = vs_rise || last ? '0 : accept && col_end ? row_q + RW'(1) : row_q;
    // BMP stores the bottom image row first, so the row index is mirrored
    row_eff = BOTTOM_UP != 0 ? 32'(IMAGE_HEIGHT - 1) - 32'(row_q) : 32'(row_q);
    addr_d  = accept ? ADDR_WIDTH'(row_eff * 32'(PAIRS) + 32'(col_q)) : addr_q;
    data_d  = accept ? {data_R_Odd, data_G_Odd, data_B_Odd, data_R_Even, data_G_Even, data_B_Even} : data_q;
    err_d   = err_q | (vs_rise && state_q == ACTIVE) | (horizontal_Pulse && !vs_rise && state_q == DONE);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      vsync_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vsync_q <= vertical_Pulse;
      col_q   <= col_d;
      row_q   <= row_d;
      we_q    <= accept;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= state_d == DONE;
      err_q   <= err_d;
      cnt_q   <= cnt_q + 8'(last);
    end
  end
  assign mem_Write_Enable = we_q;
  assign mem_Address      = addr_q;
  assign mem_Write_Data   = data_q;
  assign done_Flag        = done_q;
  assign frame_Error      = err_q;
  assign frame_Count      = cnt_q;
endmodule
